// File: rtl/tree_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined adder tree.
// Tags are carried at TAG_MAX_W bits. Narrower tags are zero-extended at the input and truncated at the output.
package tree_adder_pkg;

   localparam int TAG_MAX_W = 16;

   typedef struct packed {
      logic                 vld;
      logic                 fst;
      logic                 lst;
      logic [TAG_MAX_W-1:0] addr_i;
      logic [TAG_MAX_W-1:0] addr_k;
   } meta_t;

   function automatic int calc_log(input int n);
      return $clog2(n);
   endfunction

   function automatic int calc_stg(input int n, input int reg_every);
      return (calc_log(n) + reg_every - 1) / reg_every;
   endfunction

   // input register + tree stages + accumulator register
   function automatic int calc_lat(input int n, input int reg_every);
      return calc_stg(n, reg_every) + 2;
   endfunction

   function automatic bit level_registered(input int lvl, input int log_n, input int reg_every);
      return (((lvl + 1) % reg_every) == 0) || (lvl == log_n - 1);
   endfunction

endpackage

// File: rtl/tree_adder_level.sv
// One adder-tree level: pairwise sums of N_IN operands. Metadata rides alongside the sums.
// If REGISTERED is set, the level has a 1-cycle register that holds while en_i is low. Otherwise the level is purely combinational.
module tree_adder_level
   import tree_adder_pkg::*;
#(
   parameter int N_IN       = 2,
   parameter int W          = 20,
   parameter bit REGISTERED = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic [N_IN-1:0][W-1:0] dat_i,
   input  meta_t                 meta_i,
   output logic [N_IN/2-1:0][W-1:0] dat_o,
   output meta_t                 meta_o
);

   localparam int N_OUT = N_IN / 2;

   logic [N_OUT-1:0][W-1:0] sum_d;

   always_comb begin
      sum_d = '0;
      for (int j = 0; j < N_OUT; j++) begin
         sum_d[j] = dat_i[2*j] + dat_i[2*j+1];
      end
   end

   generate
      if (REGISTERED) begin : g_reg
         logic [N_OUT-1:0][W-1:0] sum_q;
         meta_t                   meta_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sum_q  <= '0;
               meta_q <= '0;
            end else if (en_i) begin
               sum_q  <= sum_d;
               meta_q <= meta_i;
            end
         end

         assign dat_o  = sum_q;
         assign meta_o = meta_q;
      end else begin : g_comb
         logic unused_ctl;
         assign unused_ctl = &{1'b0, clk, rst_n, en_i};
         assign dat_o      = sum_d;
         assign meta_o     = meta_i;
      end
   endgenerate

endmodule

// File: rtl/tree_adder_acc.sv
// Pipelined signed adder tree plus running accumulator. Latency is calc_lat() cycles, and all stages hold while val_out && !rdy_in.
// Defining TREE_ADDER_ACC_SAT_EN makes the accumulate saturate instead of wrapping.
module tree_adder_acc
   import tree_adder_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int DATA_LENGTH     = 16,
   parameter int ACC_WIDTH       = 20,
   parameter int REG_EVERY       = 1,
   parameter int ADDRESS_WIDTH_I = 8,
   parameter int ADDRESS_WIDTH_K = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [DATA_WIDTH*DATA_LENGTH-1:0] nums,
   input  logic                              first_in,
   input  logic                              last_in,
   input  logic [ADDRESS_WIDTH_I-1:0]        addr_i_in,
   input  logic [ADDRESS_WIDTH_K-1:0]        addr_k_in,
   input  logic                              val_in,
   output logic                              rdy_out,
   output logic [ACC_WIDTH-1:0]              sum_out,
   output logic [ADDRESS_WIDTH_I-1:0]        addr_i_out,
   output logic [ADDRESS_WIDTH_K-1:0]        addr_k_out,
   output logic                              val_out,
   input  logic                              rdy_in
);

   localparam int LOG   = calc_log(DATA_LENGTH);
   localparam int NP    = 1 << LOG;
   localparam int NODES = 2 * NP - 1;

   logic stall;
   logic val_out_q;
   assign stall   = val_out_q && !rdy_in;
   assign rdy_out = !stall;

   logic [DATA_WIDTH*DATA_LENGTH-1:0] nums_q;
   meta_t                             in_meta_d, in_meta_q;

   always_comb begin
      in_meta_d        = '0;
      in_meta_d.vld    = val_in;
      in_meta_d.fst    = first_in;
      in_meta_d.lst    = last_in;
      in_meta_d.addr_i = TAG_MAX_W'(addr_i_in);
      in_meta_d.addr_k = TAG_MAX_W'(addr_k_in);
   end

   // The stage enable equals rdy_out, so capturing val_in here is exactly the accept condition.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nums_q    <= '0;
         in_meta_q <= '0;
      end else if (!stall) begin
         nums_q    <= nums;
         in_meta_q <= in_meta_d;
      end
   end

   // The tree nodes are stored level by level. Level l starts at 2*NP - (2*NP >> l), and the root is the last node.
   logic [NODES-1:0][ACC_WIDTH-1:0] node;
   meta_t                           lvl_meta [0:LOG];

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_leaf
         if (gi < DATA_LENGTH) begin : g_dat
            assign node[gi] = ACC_WIDTH'($signed(nums_q[gi*DATA_WIDTH +: DATA_WIDTH]));
         end else begin : g_pad
            assign node[gi] = '0;
         end
      end

      for (gi = 0; gi < LOG; gi++) begin : g_lvl
         localparam int NIN     = NP >> gi;
         localparam int OFF_IN  = 2 * NP - (2 * NP >> gi);
         localparam int OFF_OUT = 2 * NP - (NP >> gi);
         tree_adder_level #(
            .N_IN       (NIN),
            .W          (ACC_WIDTH),
            .REGISTERED (level_registered(gi, LOG, REG_EVERY))
         ) u_level (
            .clk    (clk),
            .rst_n  (reset),
            .en_i   (!stall),
            .dat_i  (node[OFF_IN +: NIN]),
            .meta_i (lvl_meta[gi]),
            .dat_o  (node[OFF_OUT +: NIN/2]),
            .meta_o (lvl_meta[gi+1])
         );
      end
   endgenerate

   assign lvl_meta[0] = in_meta_q;

   meta_t                 acc_meta;
   logic [ACC_WIDTH-1:0]  tree_sum, acc_base, acc_d, acc_q;
   logic [ADDRESS_WIDTH_I-1:0] addr_i_q;
   logic [ADDRESS_WIDTH_K-1:0] addr_k_q;

   assign acc_meta = lvl_meta[LOG];
   assign tree_sum = node[NODES-1];
   assign acc_base = acc_meta.fst ? '0 : acc_q;

`ifdef TREE_ADDER_ACC_SAT_EN
   logic [ACC_WIDTH:0] acc_wide;
   always_comb begin
      acc_wide = {acc_base[ACC_WIDTH-1], acc_base} + {tree_sum[ACC_WIDTH-1], tree_sum};
      acc_d    = acc_wide[ACC_WIDTH-1:0];
      // The two top bits differ only when the signed sum left the representable range.
      if (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]) begin
         acc_d = acc_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end
`else
   assign acc_d = acc_base + tree_sum;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q     <= '0;
         val_out_q <= 1'b0;
         addr_i_q  <= '0;
         addr_k_q  <= '0;
      end else if (!stall) begin
         val_out_q <= acc_meta.vld && acc_meta.lst;
         if (acc_meta.vld) begin
            acc_q    <= acc_d;
            addr_i_q <= acc_meta.addr_i[ADDRESS_WIDTH_I-1:0];
            addr_k_q <= acc_meta.addr_k[ADDRESS_WIDTH_K-1:0];
         end
      end
   end

   logic unused_tag;
   assign unused_tag = &{1'b0, acc_meta.addr_i, acc_meta.addr_k};

   assign sum_out    = acc_q;
   assign val_out    = val_out_q;
   assign addr_i_out = addr_i_q;
   assign addr_k_out = addr_k_q;

endmodule

// File: doc/tree_adder_acc.md
TREE_ADDER_ACC -- requirements
Module: tree_adder_acc

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH (default 8), input element width, two's-complement signed; DATA_LENGTH (16), elements per beat, legal range 2..256; ACC_WIDTH (20), accumulator and output width, at least DATA_WIDTH+$clog2(DATA_LENGTH); REG_EVERY (1), tree levels per pipeline register, at least 1; ADDRESS_WIDTH_I (8) and ADDRESS_WIDTH_K (8), opaque tag widths.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- nums  in  DATA_WIDTH*DATA_LENGTH  packed elements; element i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- first_in  in  1  beat starts a new accumulation.
- last_in  in  1  beat ends the accumulation.
- addr_i_in, addr_k_in  in  ADDRESS_WIDTH_I / ADDRESS_WIDTH_K  tags.
- val_in  in  1  beat valid.
- rdy_out  out  1  block can accept a beat.
- sum_out  out  ACC_WIDTH  accumulated sum.
- addr_i_out, addr_k_out  out  tag widths  tags of the last beat.
- val_out  out  1  result valid.
- rdy_in  in  1  downstream ready.

Function
REQ-003 A beat SHALL be accepted on a rising clk edge where val_in && rdy_out.
REQ-004 Each element SHALL be sign-extended to ACC_WIDTH. Zero-padding up to the next power of two SHALL use constant zero leaves.
REQ-005 The tree SHALL have LOG=$clog2(DATA_LENGTH) adder levels, with a register after every REG_EVERY levels and after the final level. STG = ceil(LOG/REG_EVERY).
REQ-006 Pipeline depth SHALL be: 1 input register stage + STG tree stages + 1 accumulator stage = LAT. LAT = 6 for the defaults; LAT = 4 for DATA_LENGTH=16, REG_EVERY=2.
REQ-007 Valid, first, last and both tags SHALL travel alongside the data through every stage.
REQ-008 Accumulator stage: on a valid beat with first, acc = tree sum; on a valid beat without first, acc = acc + tree sum. Bubbles SHALL leave acc unchanged.
REQ-009 val_out SHALL assert only after the accumulator stage processes a beat with last. sum_out SHALL present the updated acc and tags SHALL come from that beat. Without stalls this is exactly LAT cycles after acceptance.
REQ-010 A beat with first and last both set SHALL yield its own tree sum.
REQ-011 A beat without first following a completed group SHALL accumulate onto the previous acc; no implicit clear.
REQ-012 Backpressure: stall = val_out && !rdy_in.
- While stall is high, every pipeline register and acc SHALL hold.
- rdy_out SHALL equal !stall, combinationally.
- Beats SHALL be neither dropped nor duplicated.
REQ-013 When no valid result is in the output stage, bubbles SHALL advance regardless of rdy_in.
REQ-014 Overflow without saturation SHALL wrap modulo 2^ACC_WIDTH.

Reset
REQ-015 Asserting reset SHALL immediately clear all valid bits, val_out and acc to 0. Data and tag registers are don't-care.
REQ-016 Reset mid-group or mid-stall SHALL discard all in-flight beats. After release, rdy_out=1 and the first accepted beat starts clean.

Configuration
REQ-017 With macro TREE_ADDER_ACC_SAT_EN defined, the acc update SHALL saturate to the signed ACC_WIDTH range (max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1)). Without the macro, the update SHALL wrap per REQ-014. Latency SHALL be identical in both builds.

Structure
REQ-018 Package tree_adder_pkg SHALL hold the STG/LAT computation functions and a struct bundling valid, first, last, addr_i and addr_k.
REQ-019 Sub-module tree_adder_level SHALL implement one adder level, with parameter REGISTERED and a stall-hold enable. It is instantiated LOG times.

Verification
REQ-020 The bench SHALL cover:
- Defaults, nums all 1 (8'h01), first=last=1 -> sum_out=16, val_out exactly 6 cycles after acceptance.
- Defaults, nums all 8'hFF, first=last=1 -> sum_out = -16 (20'hFFFF0).
- 3-beat group (values 1, 2, 3 in every element), then a single beat of 5 -> results 96 then 80; tags match the last beat of each group.
- val_out high with rdy_in held low for 4 cycles while val_in streams -> rdy_out low for those 4 cycles; no beat lost; result order preserved.
- ACC_WIDTH=12, group summing past 2047 -> wraps without TREE_ADDER_ACC_SAT_EN, clamps to 2047 with it.
- Reset asserted mid-group -> val_out=0 immediately; next single beat of 1s yields 16.
